reorder_buffer: RTL and testbench

//  Circular reorder buffer for the out-of-order core. Allocates one ROB tag per dispatched

---
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 tb/tb_reorder_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, collects writeback results,
// retires in program order and clears map table entries that still name the retiring tag.
module reorder_buffer #(
  parameter int ROBsize = 32,
  parameter int TAGW    = $clog2(ROBsize + 1),
  parameter int DATAW   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  input  logic             alloc_regWrite_i,
  input  logic [4:0]       alloc_destReg_i,
  output logic             alloc_ready_o,
  output logic [TAGW-1:0]  alloc_tag_o,
  input  logic             wb_valid_i,
  input  logic [TAGW-1:0]  wb_tag_i,
  input  logic [DATAW-1:0] wb_data_i,
  input  logic [TAGW-1:0]  rd1_tag_i,
  input  logic [TAGW-1:0]  rd2_tag_i,
  output logic             rd1_done_o,
  output logic             rd2_done_o,
  output logic [DATAW-1:0] rd1_data_o,
  output logic [DATAW-1:0] rd2_data_o,
  output logic [4:0]       commitReadAddr_o,
  input  logic [TAGW-1:0]  commitReadData_i,
  output logic [31:0]      resets_o,
  output logic             commit_valid_o,
  output logic             commit_regWrite_o,
  output logic [4:0]       commit_destReg_o,
  output logic [DATAW-1:0] commit_data_o,
  output logic [TAGW-1:0]  commit_tag_o,
  output logic [TAGW-1:0]  count_o
);

  localparam int              PTRW = $clog2(ROBsize);
  localparam logic [TAGW-1:0] FULL = TAGW'(ROBsize);
  localparam logic [PTRW-1:0] LAST = PTRW'(ROBsize - 1);

  logic [ROBsize-1:0] ent_valid;
  logic [ROBsize-1:0] ent_done;
  logic [ROBsize-1:0] ent_regwrite;
  logic [4:0]         ent_dest [ROBsize];
  logic [DATAW-1:0]   ent_data [ROBsize];

  logic [PTRW-1:0] head, tail;
  logic [TAGW-1:0] count;
  logic [TAGW-1:0] head_tag;
  logic [PTRW-1:0] wb_idx;
  logic            alloc_fire, wb_fire, head_retire;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic tag_in_range(input logic [TAGW-1:0] t);
    return (t != '0) && (t <= FULL);
  endfunction

  function automatic logic [PTRW-1:0] tag_idx(input logic [TAGW-1:0] t);
    return PTRW'(t - 1'b1);
  endfunction

  // Operand lookup: the in-flight writeback wins over the stored entry.
  function automatic logic [DATAW:0] rd_lookup(input logic [TAGW-1:0] t);
    logic [PTRW-1:0] i;
    i = tag_idx(t);
    if (!tag_in_range(t))
      return '0;
    if (wb_fire && (wb_tag_i == t))
      return {1'b1, wb_data_i};
    return {ent_valid[i] & ent_done[i], ent_data[i]};
  endfunction

  assign alloc_ready_o    = (count < FULL);
  assign alloc_tag_o      = TAGW'(tail) + 1'b1;
  assign alloc_fire       = alloc_valid_i & alloc_ready_o;
  assign count_o          = count;

  assign wb_idx           = tag_idx(wb_tag_i);
  assign wb_fire          = wb_valid_i & ~flush_i & tag_in_range(wb_tag_i) & ent_valid[wb_idx];

  assign head_tag         = TAGW'(head) + 1'b1;
  assign head_retire      = ent_valid[head] & ent_done[head];
  assign commit_valid_o   = head_retire & ~flush_i;
  assign commit_regWrite_o = commit_valid_o & ent_regwrite[head];
  assign commit_destReg_o = commit_valid_o ? ent_dest[head] : '0;
  assign commit_data_o    = commit_valid_o ? ent_data[head] : '0;
  assign commit_tag_o     = commit_valid_o ? head_tag : '0;
  assign commitReadAddr_o = ent_dest[head];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    resets_o = '0;
    if (commit_regWrite_o && (commitReadData_i == head_tag) && (ent_dest[head] != 5'd31))
      resets_o[ent_dest[head]] = 1'b1;
  end

  always_comb begin
    {rd1_done_o, rd1_data_o} = rd_lookup(rd1_tag_i);
    {rd2_done_o, rd2_data_o} = rd_lookup(rd2_tag_i);
  end

  // NOTE: state updates use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the payload arrays are cleared too, so commitReadAddr_o and operand data
      // are defined straight out of reset; flush only needs to drop the valid bits.
      ent_valid    <= '0;
      ent_done     <= '0;
      ent_regwrite <= '0;
      for (int i = 0; i < ROBsize; i++) begin
        ent_dest[i] <= '0;
        ent_data[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (alloc_fire) begin
        ent_valid[tail]    <= 1'b1;
        ent_done[tail]     <= 1'b0;
        ent_regwrite[tail] <= alloc_regWrite_i;
        ent_dest[tail]     <= alloc_destReg_i;
        tail               <= ptr_inc(tail);
      end
      if (wb_fire) begin
        ent_done[wb_idx] <= 1'b1;
        ent_data[wb_idx] <= wb_data_i;
      end
      if (commit_valid_o) begin
        ent_valid[head] <= 1'b0;
        head            <= ptr_inc(head);
      end
      case ({alloc_fire, commit_valid_o})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scoreboard of allocated tags checked at commit,
// plus directed scenarios for fullness, wrap, bypass, flush and ignored writebacks.
module tb_reorder_buffer;

  localparam int TAGW  = 6;
  localparam int DATAW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_i;
  logic             alloc_valid_i;
  logic             alloc_regWrite_i;
  logic [4:0]       alloc_destReg_i;
  logic             alloc_ready_o;
  logic [TAGW-1:0]  alloc_tag_o;
  logic             wb_valid_i;
  logic [TAGW-1:0]  wb_tag_i;
  logic [DATAW-1:0] wb_data_i;
  logic [TAGW-1:0]  rd1_tag_i, rd2_tag_i;
  logic             rd1_done_o, rd2_done_o;
  logic [DATAW-1:0] rd1_data_o, rd2_data_o;
  logic [4:0]       commitReadAddr_o;
  logic [TAGW-1:0]  commitReadData_i;
  logic [31:0]      resets_o;
  logic             commit_valid_o;
  logic             commit_regWrite_o;
  logic [4:0]       commit_destReg_o;
  logic [DATAW-1:0] commit_data_o;
  logic [TAGW-1:0]  commit_tag_o;
  logic [TAGW-1:0]  count_o;

  reorder_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (flush_i),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_regWrite_i (alloc_regWrite_i),
    .alloc_destReg_i  (alloc_destReg_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_tag_o      (alloc_tag_o),
    .wb_valid_i       (wb_valid_i),
    .wb_tag_i         (wb_tag_i),
    .wb_data_i        (wb_data_i),
    .rd1_tag_i        (rd1_tag_i),
    .rd2_tag_i        (rd2_tag_i),
    .rd1_done_o       (rd1_done_o),
    .rd2_done_o       (rd2_done_o),
    .rd1_data_o       (rd1_data_o),
    .rd2_data_o       (rd2_data_o),
    .commitReadAddr_o (commitReadAddr_o),
    .commitReadData_i (commitReadData_i),
    .resets_o         (resets_o),
    .commit_valid_o   (commit_valid_o),
    .commit_regWrite_o(commit_regWrite_o),
    .commit_destReg_o (commit_destReg_o),
    .commit_data_o    (commit_data_o),
    .commit_tag_o     (commit_tag_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [4:0]      dest;
    logic            rw;
  } exp_t;

  exp_t             sb[$];
  logic [DATAW-1:0] mdata [64];
  int               m_tail;
  int               m_count;
  int               errors = 0;
  int               checks = 0;

  // Advance one cycle; any commit seen before the edge is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    if (!reset && !flush_i && commit_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got tag %0d, expected no commit", commit_tag_o);
      end else begin
        e = sb.pop_front();
        m_count--;
        if ({commit_tag_o, commit_destReg_o, commit_regWrite_o, commit_data_o} !==
            {e.tag, e.dest, e.rw, mdata[e.tag]}) begin
          errors++;
          $display("FAIL commit_entry: got tag=%0d rd=%0d rw=%0b data=%0h, expected tag=%0d rd=%0d rw=%0b data=%0h",
                   commit_tag_o, commit_destReg_o, commit_regWrite_o, commit_data_o,
                   e.tag, e.dest, e.rw, mdata[e.tag]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    m_tail  = 0;
    m_count = 0;
  endtask

  task automatic alloc1(input logic [4:0] dest, input logic rw);
    exp_t e;
    alloc_valid_i    = 1'b1;
    alloc_destReg_i  = dest;
    alloc_regWrite_i = rw;
    #1;
    if (m_count < 32) begin
      checks++;
      if (alloc_tag_o !== TAGW'(m_tail + 1)) begin
        errors++;
        $display("FAIL alloc_tag: got %0d expected %0d", alloc_tag_o, m_tail + 1);
      end
      e.tag  = TAGW'(m_tail + 1);
      e.dest = dest;
      e.rw   = rw;
      sb.push_back(e);
      m_tail = (m_tail + 1) % 32;
      m_count++;
    end
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic wb1(input logic [TAGW-1:0] tag, input logic [DATAW-1:0] data);
    wb_valid_i = 1'b1;
    wb_tag_i   = tag;
    wb_data_i  = data;
    if (tag >= 1 && tag <= 32) mdata[tag] = data;
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic check_count(input string name, input int exp);
    checks++;
    if (count_o !== TAGW'(exp)) begin
      errors++;
      $display("FAIL %s: count_o got %0d expected %0d", name, count_o, exp);
    end
  endtask

  task automatic check_commit_valid(input string name, input logic exp);
    checks++;
    if (commit_valid_o !== exp) begin
      errors++;
      $display("FAIL %s: commit_valid_o got %0b expected %0b", name, commit_valid_o, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({alloc_ready_o, alloc_tag_o, commit_tag_o, resets_o, rd1_done_o} !==
        {1'b1, TAGW'(1), TAGW'(0), 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b tag=%0d ctag=%0d resets=%0h rd1done=%0b, expected 1 1 0 0 0",
               alloc_ready_o, alloc_tag_o, commit_tag_o, resets_o, rd1_done_o);
    end
    check_count("reset_count", 0);
    check_commit_valid("reset_commit", 1'b0);
  endtask

  task automatic test_in_order_commit();
    alloc1(5'd1, 1'b1);
    alloc1(5'd2, 1'b1);
    alloc1(5'd1, 1'b1);
    check_count("basic_count3", 3);
    check_commit_valid("basic_no_commit", 1'b0);
    wb1(6'd2, 32'h22);
    check_commit_valid("wb_tag2_no_commit", 1'b0);
    wb_valid_i = 1'b1; wb_tag_i = 6'd1; wb_data_i = 32'h11; mdata[1] = 32'h11;
    #1;
    check_commit_valid("wb_head_same_cycle", 1'b0);
    tick();
    wb_valid_i = 1'b0;
    commitReadData_i = 6'd3;
    #1;
    check_commit_valid("commit_tag1", 1'b1);
    checks++;
    if ({commitReadAddr_o, resets_o} !== {5'd1, 32'h0}) begin
      errors++;
      $display("FAIL stale_map_reset: got addr=%0d resets=%0h expected addr=1 resets=0", commitReadAddr_o, resets_o);
    end
    tick();
    commitReadData_i = 6'd2;
    #1;
    check_commit_valid("commit_tag2", 1'b1);
    checks++;
    if (resets_o !== 32'h4) begin
      errors++;
      $display("FAIL map_reset_r2: got %0h expected 4", resets_o);
    end
    tick();
    commitReadData_i = '0;
    check_commit_valid("tag3_not_done", 1'b0);
    check_count("basic_count1", 1);
    wb1(6'd3, 32'h33);
    tick();
    check_count("basic_drained", 0);
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 32; i++) alloc1(5'(i), 1'b1);
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %0b expected 0", alloc_ready_o);
    end
    check_count("full_count", 32);
    alloc1(5'd9, 1'b1);
    check_count("full_33rd_ignored", 32);
    wb1(6'd1, 32'hA1);
    tick();
    checks++;
    if ({alloc_ready_o, alloc_tag_o} !== {1'b1, TAGW'(1)}) begin
      errors++;
      $display("FAIL wrap_ready_tag: got ready=%0b tag=%0d expected ready=1 tag=1", alloc_ready_o, alloc_tag_o);
    end
    check_count("after_one_commit", 31);
    alloc1(5'd3, 1'b1);
    check_count("refill_count", 32);
  endtask

  task automatic test_bypass();
    rd1_tag_i = 6'd5;
    rd2_tag_i = 6'd0;
    #1;
    checks++;
    if (rd1_done_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_not_done: got %0b expected 0", rd1_done_o);
    end
    wb_valid_i = 1'b1; wb_tag_i = 6'd5; wb_data_i = 32'hDEAD; mdata[5] = 32'hDEAD;
    #1;
    checks++;
    if ({rd1_done_o, rd1_data_o, rd2_done_o, rd2_data_o} !== {1'b1, 32'hDEAD, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rd_bypass: got d1=%0b %0h d2=%0b %0h expected 1 dead 0 0",
               rd1_done_o, rd1_data_o, rd2_done_o, rd2_data_o);
    end
    tick();
    wb_valid_i = 1'b0;
    #1;
    checks++;
    if ({rd1_done_o, rd1_data_o} !== {1'b1, 32'hDEAD}) begin
      errors++;
      $display("FAIL rd_stored: got %0b %0h expected 1 dead", rd1_done_o, rd1_data_o);
    end
    rd1_tag_i = '0;
  endtask

  task automatic test_back_to_back_and_flush();
    test_reset();
    for (int i = 0; i < 4; i++) alloc1(5'(i + 4), 1'b1);
    wb1(6'd1, 32'h1111);
    check_commit_valid("b2b_head_ready", 1'b1);
    alloc1(5'd8, 1'b1);
    check_count("alloc_commit_same_cycle", 4);
    wb1(6'd2, 32'h2222);
    flush_i = 1'b1;
    alloc_valid_i = 1'b1;
    commitReadData_i = 6'd2;
    #1;
    check_commit_valid("flush_blocks_commit", 1'b0);
    checks++;
    if (resets_o !== 32'h0) begin
      errors++;
      $display("FAIL flush_resets: got %0h expected 0", resets_o);
    end
    tick();
    flush_i = 1'b0;
    alloc_valid_i = 1'b0;
    commitReadData_i = '0;
    model_clear();
    check_count("flush_count", 0);
    checks++;
    if (alloc_tag_o !== TAGW'(1)) begin
      errors++;
      $display("FAIL flush_tag: got %0d expected 1", alloc_tag_o);
    end
    check_commit_valid("after_flush_commit", 1'b0);
  endtask

  task automatic test_ignored_wb();
    alloc1(5'd31, 1'b1);
    alloc1(5'd7, 1'b0);
    wb1(6'd0, 32'hBAD0);
    wb1(6'd5, 32'hBAD5);
    wb1(6'd40, 32'hBAD4);
    check_commit_valid("ignored_wb_commit", 1'b0);
    check_count("ignored_wb_count", 2);
    rd1_tag_i = 6'd1;
    rd2_tag_i = 6'd5;
    #1;
    checks++;
    if ({rd1_done_o, rd2_done_o} !== 2'b00) begin
      errors++;
      $display("FAIL ignored_wb_done: got %0b%0b expected 00", rd1_done_o, rd2_done_o);
    end
    rd1_tag_i = '0;
    rd2_tag_i = '0;
    wb1(6'd1, 32'h3131);
    commitReadData_i = 6'd1;
    #1;
    checks++;
    if ({commit_valid_o, resets_o} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL r31_never_reset: got valid=%0b resets=%0h expected 1 0", commit_valid_o, resets_o);
    end
    tick();
    wb1(6'd2, 32'h0707);
    commitReadData_i = 6'd2;
    #1;
    checks++;
    if ({commit_valid_o, commit_regWrite_o, resets_o} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL no_regwrite_reset: got valid=%0b rw=%0b resets=%0h expected 1 0 0",
               commit_valid_o, commit_regWrite_o, resets_o);
    end
    tick();
    commitReadData_i = '0;
    check_count("ignored_drained", 0);
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0;
    alloc_valid_i = 1'b0; alloc_regWrite_i = 1'b0; alloc_destReg_i = '0;
    wb_valid_i = 1'b0; wb_tag_i = '0; wb_data_i = '0;
    rd1_tag_i = '0; rd2_tag_i = '0; commitReadData_i = '0;
    for (int i = 0; i < 64; i++) mdata[i] = '0;
    model_clear();

    test_reset();
    test_in_order_commit();
    test_reset();
    test_full_wrap();
    test_bypass();
    test_back_to_back_and_flush();
    test_ignored_wb();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
